// File: rtl/arb2_reg_ctrl_pkg.sv
// arb2_reg_ctrl_pkg: shared state encodings and hold limit for the two-requester register arbiter
package arb2_reg_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, G0 = 2'b01, G1 = 2'b10} state_t;
  localparam logic [2:0] HOLD_MAX = 3'd7;
endpackage

// File: rtl/arb2_reg_ctrl_fsm.sv
// arb2_reg_ctrl_fsm: round-robin grant FSM with 8-cycle hold limit and registered grant decode
module arb2_reg_ctrl_fsm
  import arb2_reg_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic busy
);
  logic [1:0] state_q;
  logic [2:0] cnt_q, cnt_d;
  logic pri_q, pri_d, own_req, oth_req, rel;
  state_t st, state_d;
  dff_ar #(.W(2)) u_state (.clk(clk), .rst(rst), .d(state_d), .q(state_q));
  dff_ar #(.W(1)) u_pri (.clk(clk), .rst(rst), .d(pri_d), .q(pri_q));
  dff_ar #(.W(3)) u_cnt (.clk(clk), .rst(rst), .d(cnt_d), .q(cnt_q));
  assign st = state_t'(state_q);
  assign own_req = (st == G1) ? req1 : req0;
  assign oth_req = (st == G1) ? req0 : req1;
  assign rel = !own_req || cnt_q == HOLD_MAX;
  // a timed-out owner with no contender keeps the grant and cnt restarts at 0
  always_comb begin
    state_d = st;
    pri_d = pri_q;
    cnt_d = 3'd0;
    if (st != G0 && st != G1)
      state_d = (req0 && req1) ? (pri_q ? G1 : G0) : req0 ? G0 : req1 ? G1 : IDLE;
    else if (!rel)
      cnt_d = cnt_q + 3'd1;
    else if (oth_req || !own_req) begin
      state_d = oth_req ? ((st == G0) ? G1 : G0) : IDLE;
      pri_d = (st == G0);
    end
  end
  assign gnt0 = (st == G0);
  assign gnt1 = (st == G1);
  assign sel = gnt1;
  assign busy = gnt0 | gnt1;
endmodule

// File: rtl/dff_ar.sv
// dff_ar: D flip-flop bank with asynchronous active-high reset to zero
module dff_ar #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else q <= d;
endmodule

// File: rtl/mux2.sv
// mux2: single-bit 2-to-1 multiplexer, s=1 selects b
module mux2 (
  input  logic s,
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = s ? b : a;
endmodule

// File: rtl/arb2_reg_ctrl.sv
// arb2_reg_ctrl: two-requester arbitrated 4-bit shared register
module arb2_reg_ctrl
  import arb2_reg_ctrl_pkg::*;
(
  input  logic       c,
  input  logic       re,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       sel,
  output logic       we,
  output logic       busy,
  output logic [3:0] q
);
  logic [3:0] m, q_d;
  arb2_reg_ctrl_fsm u_fsm (
    .clk(c), .rst(re), .req0(req0), .req1(req1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .busy(busy)
  );
  assign we = (gnt0 & req0) | (gnt1 & req1);
  for (genvar i = 0; i < 4; i++) begin : g_bit
    mux2 u_sel (.s(sel), .a(d0[i]), .b(d1[i]), .y(m[i]));
    mux2 u_hold (.s(we), .a(q[i]), .b(m[i]), .y(q_d[i]));
  end
  dff_ar #(.W(4)) u_q (.clk(c), .rst(re), .d(q_d), .q(q));
endmodule

// File: tb/tb_arb2_reg_ctrl.sv
// tb_arb2_reg_ctrl: directed and random checks of arbitration, hold limit, writes and reset
module tb_arb2_reg_ctrl;
  logic c = 1'b0, re, req0, req1, gnt0, gnt1, sel, we, busy;
  logic [3:0] d0, d1, q;
  int total = 0, bad = 0, wait0 = 0, wait1 = 0, max_wait = 0;

  arb2_reg_ctrl dut (
    .c(c), .re(re), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .we(we), .busy(busy), .q(q)
  );

  always #5 c = ~c;

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  // observed vector layout: {gnt0, gnt1, sel, busy, we, q[3:0]}
  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {gnt0, gnt1, sel, busy, we, q};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    re = 1'b1; req0 = 1'b0; req1 = 1'b0; d0 = 4'h3; d1 = 4'hC;
    tick();
    chk("reset_state", 9'b0_0_0_0_0_0000);
    re = 1'b0; req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("both_req_g0", 9'b1_0_0_1_1_0000);
    req0 = 1'b0;
    #1 chk("g0_req_drop_no_we", 9'b1_0_0_1_0_0000);
    tick();
    chk("handover_g1_no_idle", 9'b0_1_1_1_1_0000);
    tick();
    chk("g1_write_c", 9'b0_1_1_1_1_1100);
    tick();
    tick();
    re = 1'b1;
    #1 chk("async_reset_mid_g1", 9'b0_0_0_0_0_0000);
    tick();
    re = 1'b0; req0 = 1'b1; req1 = 1'b0; d0 = 4'hA;
    tick();
    chk("after_reset_g0", 9'b1_0_0_1_1_0000);
    tick();
    chk("q_a_one_edge", 9'b1_0_0_1_1_1010);
    for (int i = 0; i < 18; i++) begin
      tick();
      chk($sformatf("g0_hold_%0d", i), 9'b1_0_0_1_1_1010);
    end
    req0 = 1'b0; d0 = 4'h5;
    #1 chk("g0_owner_low_no_we", 9'b1_0_0_1_0_1010);
    tick();
    chk("release_to_idle", 9'b0_0_0_0_0_1010);
    req0 = 1'b1; req1 = 1'b1; d0 = 4'h3; d1 = 4'hC;
    tick();
    chk("pri1_g1_first", 9'b0_1_1_1_1_1010);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("alt_g1_%0d", i), 9'b0_1_1_1_1_1100);
    end
    tick();
    chk("alt_to_g0", 9'b1_0_0_1_1_1100);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("alt_g0_%0d", i), 9'b1_0_0_1_1_0011);
    end
    tick();
    chk("alt_back_g1", 9'b0_1_1_1_1_0011);
    tick();
    chk("alt_g1_q_c", 9'b0_1_1_1_1_1100);
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      re = ($urandom_range(0, 199) == 0);
      d0 = 4'($urandom);
      d1 = 4'($urandom);
      tick();
      chk1("mutex", gnt0 & gnt1, 1'b0);
      if (re) chk1("reset_busy", busy, 1'b0);
      wait0 = (re || !req0 || gnt0) ? 0 : wait0 + 1;
      wait1 = (re || !req1 || gnt1) ? 0 : wait1 + 1;
      if (wait0 > max_wait) max_wait = wait0;
      if (wait1 > max_wait) max_wait = wait1;
    end
    chk1("max_wait_le_9", max_wait <= 9, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
